engine_forward_data_arbiter_n_to_1: RTL and testbench
=====================================================

ENGINE_FORWARD_DATA_ARBITER_N_TO_1 -- requirements
Module: engine_forward_data_arbiter_n_to_1

Interface
REQ-001 Parameter NUM_REQUESTORS, default 4: number of forward-data generator request streams merged; legal range 2..16.
REQ-002 Parameter COUNTER_WIDTH, default M00_AXI4_FE_ADDR_W: width of the forwarded-packet counter.
REQ-003 ap_clk  input  1  sole clock; all logic on rising edge.
REQ-004 areset  input  1  synchronous, active-high reset.
REQ-005 start_in  input  1  single-cycle pulse: begin arbitration session.
REQ-006 request_in[NUM_REQUESTORS]  input  EnginePacket  head of each requester's FWFT FIFO; valid = non-empty.
REQ-007 requestor_done_in[NUM_REQUESTORS]  input  1 each  requester has no further packets this session.
REQ-008 grant_out[NUM_REQUESTORS]  output  1 each  combinational one-hot pop to the granted requester's FIFO.
REQ-009 downstream_ready_in  input  1  downstream can accept (inverse of its prog_full).
REQ-010 request_out  output  EnginePacket  merged stream, registered.
REQ-011 packet_count_out  output  COUNTER_WIDTH  packets forwarded this session.
REQ-012 done_out  output  1  session complete, registered.

Function
REQ-013 downstream_ready_in SHALL be registered once (ready_reg) before use; the 1-cycle skew is covered by downstream prog_full slack.
REQ-014 FSM states: IDLE, ACTIVE, DRAIN, DONE; reset enters IDLE.
REQ-015 IDLE -> ACTIVE on start_in; no grants in IDLE or DONE.
REQ-016 ACTIVE -> DRAIN when all requestor_done_in = 1 and no request_in.valid is asserted.
REQ-017 DRAIN SHALL hold exactly 1 cycle so the last registered packet exits, then -> DONE.
REQ-018 DONE: done_out = 1; start_in returns to ACTIVE, clears packet_count_out and done_out next cycle.
REQ-019 In ACTIVE, at most one grant_out bit SHALL be high per cycle, and only when ready_reg = 1 and the granted request_in.valid = 1.
REQ-020 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod NUM_REQUESTORS; last_grant updates only on an actual grant; reset value of last_grant = NUM_REQUESTORS-1 (so requester 0 wins first).
REQ-021 Grant in cycle t SHALL yield request_out.valid = 1 with the granted payload unmodified in cycle t+1 (latency 1); otherwise request_out.valid = 0.
REQ-022 packet_count_out SHALL increment by 1 per grant, wrapping modulo 2^COUNTER_WIDTH without flag.
REQ-023 requestor_done_in = 1 with that request_in.valid = 1 SHALL still be serviced; done only counts once valid drops.
REQ-024 start_in while ACTIVE or DRAIN SHALL be ignored.
REQ-025 ready_reg = 0 SHALL suppress grants without altering last_grant; arbitration resumes from the same pointer.
REQ-026 A single valid requester SHALL be granted every cycle while ready_reg = 1 (full throughput, no bubbles).

Reset
REQ-027 Reset SHALL force: FSM IDLE, grant_out = 0, request_out.valid = 0, packet_count_out = 0, done_out = 0, ready_reg = 0, last_grant = NUM_REQUESTORS-1; payload registers need no reset.
REQ-028 Reset asserted mid-ACTIVE SHALL take effect the next edge; no grant_out asserted during the reset cycle or the first cycle after.

Verification
REQ-029 N=4, start, all four valid, ready high for 8 cycles -> grants 0,1,2,3,0,1,2,3; request_out payloads match, packet_count_out = 8.
REQ-030 Only requester 2 valid, ready high 5 cycles -> grant_out[2] high 5 consecutive cycles, 5 back-to-back request_out.valid.
REQ-031 All valid, ready deasserted after grant to 1 for 3 cycles -> no grants (1-cycle skew), next grant is requester 2.
REQ-032 All requestor_done_in = 1, last packet granted cycle t -> request_out.valid at t+1, DRAIN, done_out = 1 at DONE; second start_in clears count to 0.
REQ-033 COUNTER_WIDTH = 4, 17 grants -> packet_count_out = 1.
REQ-034 areset pulsed mid-stream with all valid -> all outputs at reset values next cycle; after new start_in first grant is requester 0.

Source files
------------

// File: rtl/engine_forward_data_arbiter_n_to_1.sv
// -----------------------------------------------------------------------------
// engine_forward_data_arbiter_n_to_1
//
// Merges NUM_REQUESTORS forward-data generator streams into one registered
// output stream using round-robin arbitration. Each requester presents the
// head of a first-word-fall-through FIFO; the arbiter pops it with a
// combinational one-hot grant. A session is opened by start_in, runs until
// every requester reports done and has drained its FIFO, then waits one
// extra cycle so the last registered packet leaves before done_out rises.
//
// Ports
//   ap_clk               sole clock, rising edge
//   areset               synchronous active-high reset
//   start_in             one-cycle pulse opening an arbitration session
//   request_in[N]        FIFO heads (valid = FIFO non-empty)
//   requestor_done_in    per-requester "no more packets this session"
//   grant_out            combinational one-hot pop to the granted FIFO
//   downstream_ready_in  downstream can accept (registered once internally)
//   request_out          merged stream, registered, latency 1 from grant
//   packet_count_out     packets forwarded this session (wraps silently)
//   done_out             session complete, registered
//
// NUM_REQUESTORS is intended for the range 2..16.
// -----------------------------------------------------------------------------

package engine_forward_data_arbiter_n_to_1_pkg;

  localparam int M00_AXI4_FE_ADDR_W   = 32;
  localparam int ENGINE_PACKET_DATA_W = 32;

  typedef struct packed {
    logic                            valid;
    logic [ENGINE_PACKET_DATA_W-1:0] payload;
  } engine_packet_t;

endpackage

module engine_forward_data_arbiter_n_to_1
  import engine_forward_data_arbiter_n_to_1_pkg::*;
#(
  parameter int NUM_REQUESTORS = 4,
  parameter int COUNTER_WIDTH  = M00_AXI4_FE_ADDR_W
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      start_in,
  input  engine_packet_t            request_in [NUM_REQUESTORS],
  input  logic [NUM_REQUESTORS-1:0] requestor_done_in,
  output logic [NUM_REQUESTORS-1:0] grant_out,
  input  logic                      downstream_ready_in,
  output engine_packet_t            request_out,
  output logic [COUNTER_WIDTH-1:0]  packet_count_out,
  output logic                      done_out
);

  localparam int          IDX_W = $clog2(NUM_REQUESTORS);
  localparam int unsigned N_U   = NUM_REQUESTORS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUESTORS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                state_r;
  logic [1:0]                state_nxt_s;
  logic                      ready_r;
  logic [IDX_W-1:0]          last_grant_r;
  logic [NUM_REQUESTORS-1:0] valid_vec_s;
  logic                      all_done_s;
  logic                      any_valid_s;
  logic                      start_accept_s;
  logic                      grant_found_s;
  logic [IDX_W-1:0]          grant_idx_s;
  logic                      grant_fire_s;
  logic                      out_valid_r;
  logic [ENGINE_PACKET_DATA_W-1:0] out_payload_r;
  logic [COUNTER_WIDTH-1:0]  count_r;
  logic                      done_r;

  // Index visited at position 'offset' of the round-robin search that
  // begins just after 'base'. base+1+offset never exceeds 2N-1, so a single
  // conditional subtraction implements the modulo.
  function automatic logic [IDX_W-1:0] rr_candidate(input logic [IDX_W-1:0] base,
                                                    input int unsigned      offset);
    int unsigned sum_v;
    sum_v = 32'(base) + 32'd1 + offset;
    if (sum_v >= N_U) begin
      sum_v = sum_v - N_U;
    end else begin
      sum_v = sum_v;
    end
    return sum_v[IDX_W-1:0];
  endfunction

  // Gather the per-requester valid flags into a vector.
  always_comb begin
    valid_vec_s = {NUM_REQUESTORS{1'b0}};
    for (int i = 0; i < NUM_REQUESTORS; i++) begin
      valid_vec_s[i] = request_in[i].valid;
    end
  end

  assign all_done_s     = &requestor_done_in;
  assign any_valid_s    = |valid_vec_s;
  // start_in only opens a session from IDLE or DONE; elsewhere it is ignored.
  assign start_accept_s = start_in && ((state_r == S_IDLE) || (state_r == S_DONE));

  // Session sequencing; ACTIVE ends only once every requester is done and
  // its FIFO is empty, so a done requester with a pending head is still served.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_in) begin
          state_nxt_s = S_ACTIVE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (all_done_s && !any_valid_s) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_ACTIVE;
        end
      end
      S_DRAIN: begin
        state_nxt_s = S_DONE;
      end
      S_DONE: begin
        if (start_in) begin
          state_nxt_s = S_ACTIVE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Round-robin search: first valid requester after the last one granted.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDX_W{1'b0}};
    for (int unsigned k = 0; k < N_U; k++) begin
      if (!grant_found_s && valid_vec_s[rr_candidate(last_grant_r, k)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = rr_candidate(last_grant_r, k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // A grant needs an active session and last cycle's downstream ready; it is
  // also masked while reset is being applied so no FIFO is popped then.
  assign grant_fire_s = grant_found_s && ready_r && (state_r == S_ACTIVE) && !areset;

  // Decode the winning index into the one-hot pop vector.
  always_comb begin
    grant_out = {NUM_REQUESTORS{1'b0}};
    for (int i = 0; i < NUM_REQUESTORS; i++) begin
      if (grant_fire_s && (grant_idx_s == IDX_W'(i))) begin
        grant_out[i] = 1'b1;
      end else begin
        grant_out[i] = 1'b0;
      end
    end
  end

  // Control state: FSM, ready pipeline stage, round-robin pointer, output valid.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_r      <= S_IDLE;
      ready_r      <= 1'b0;
      last_grant_r <= LAST_IDX;
      out_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ready_r     <= downstream_ready_in;
      out_valid_r <= grant_fire_s;
      // Pointer moves only on a real grant, so a stalled downstream resumes
      // arbitration from the same place.
      if (grant_fire_s) begin
        last_grant_r <= grant_idx_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Forwarded payload; it is only meaningful alongside out_valid_r.
  always_ff @(posedge ap_clk) begin
    if (grant_fire_s) begin
      out_payload_r <= request_in[grant_idx_s].payload;
    end else begin
      out_payload_r <= out_payload_r;
    end
  end

  // Per-session packet counter, wraps modulo 2^COUNTER_WIDTH.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      count_r <= {COUNTER_WIDTH{1'b0}};
    end else if (start_accept_s) begin
      count_r <= {COUNTER_WIDTH{1'b0}};
    end else if (grant_fire_s) begin
      count_r <= count_r + COUNTER_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Done flag rises as DRAIN hands over to DONE and clears on a new start.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      done_r <= 1'b0;
    end else if (state_r == S_DRAIN) begin
      done_r <= 1'b1;
    end else if ((state_r == S_DONE) && start_in) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_r;
    end
  end

  // Present the registered packet on the output struct.
  always_comb begin
    request_out.valid   = out_valid_r;
    request_out.payload = out_payload_r;
  end

  assign packet_count_out = count_r;
  assign done_out         = done_r;

endmodule

// File: tb/tb_engine_forward_data_arbiter_n_to_1.sv
// Bench for engine_forward_data_arbiter_n_to_1: a directed vector table walks
// the session/arbitration corner cases, then randomized traffic is compared
// against a behavioural model of the arbitration rules.
module tb_engine_forward_data_arbiter_n_to_1;
  import engine_forward_data_arbiter_n_to_1_pkg::*;

  localparam int N  = 4;
  localparam int CW = 4;

  localparam int PH_IDLE   = 0;
  localparam int PH_ACTIVE = 1;
  localparam int PH_DRAIN  = 2;
  localparam int PH_DONE   = 3;

  logic           ap_clk = 1'b0;
  logic           areset;
  logic           start_in;
  engine_packet_t request_in [N];
  logic [N-1:0]   requestor_done_in;
  logic [N-1:0]   grant_out;
  logic           downstream_ready_in;
  engine_packet_t request_out;
  logic [CW-1:0]  packet_count_out;
  logic           done_out;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int          m_phase;
  int          m_ptr;
  bit          m_rdy;
  bit          m_ovalid;
  logic [31:0] m_opayload;
  int          m_cnt;

  typedef struct {
    bit         start;
    bit         rst;
    bit         ready;
    logic [3:0] valid;
    logic [3:0] rdone;
    logic [3:0] exp_grant;
    int         exp_cnt;
    bit         exp_done;
  } vec_t;

  vec_t tab[$];

  always #5 ap_clk = ~ap_clk;

  engine_forward_data_arbiter_n_to_1 #(
    .NUM_REQUESTORS(N),
    .COUNTER_WIDTH (CW)
  ) dut (
    .ap_clk             (ap_clk),
    .areset             (areset),
    .start_in           (start_in),
    .request_in         (request_in),
    .requestor_done_in  (requestor_done_in),
    .grant_out          (grant_out),
    .downstream_ready_in(downstream_ready_in),
    .request_out        (request_out),
    .packet_count_out   (packet_count_out),
    .done_out           (done_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit st, input bit rs, input bit rd, input logic [3:0] v,
                              input logic [3:0] dn, input logic [3:0] g, input int c, input bit d);
    vec_t r;
    r.start = st; r.rst = rs; r.ready = rd; r.valid = v; r.rdone = dn;
    r.exp_grant = g; r.exp_cnt = c; r.exp_done = d;
    tab.push_back(r);
  endfunction

  // Expected granted requester this cycle, -1 when nobody may be granted.
  function automatic int model_grant();
    if (areset || (m_phase != PH_ACTIVE) || !m_rdy) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + 1 + k) % N;
      if (request_in[idx].valid) return idx;
    end
    return -1;
  endfunction

  // Advance the model across one rising edge using the inputs held this cycle.
  task automatic model_step(input int g);
    bit any_v;
    any_v = 1'b0;
    for (int i = 0; i < N; i++) if (request_in[i].valid) any_v = 1'b1;
    if (areset) begin
      m_phase = PH_IDLE; m_ptr = N - 1; m_rdy = 1'b0; m_ovalid = 1'b0; m_cnt = 0;
    end else begin
      m_ovalid = (g >= 0);
      if (g >= 0) begin
        m_opayload = request_in[g].payload;
        m_ptr      = g;
        m_cnt      = (m_cnt + 1) % (1 << CW);
      end
      m_rdy = downstream_ready_in;
      case (m_phase)
        PH_IDLE:   if (start_in) begin m_phase = PH_ACTIVE; m_cnt = 0; end
        PH_ACTIVE: if ((&requestor_done_in) && !any_v) m_phase = PH_DRAIN;
        PH_DRAIN:  m_phase = PH_DONE;
        default:   if (start_in) begin m_phase = PH_ACTIVE; m_cnt = 0; end
      endcase
    end
  endtask

  // One clock: grant checked at the falling edge, registered outputs 1 time
  // unit after the rising edge.
  task automatic run_cycle(input bit use_tab, input logic [3:0] t_grant, input int t_cnt, input bit t_done);
    int           g;
    logic [N-1:0] exp_g;
    @(negedge ap_clk);
    g     = model_grant();
    exp_g = (g < 0) ? '0 : (N'(1) << g);
    check("grant_model", 64'(grant_out), 64'(exp_g));
    if (use_tab) check("grant_table", 64'(grant_out), 64'(t_grant));
    @(posedge ap_clk);
    model_step(g);
    #1;
    check("out_valid", 64'(request_out.valid), 64'(m_ovalid));
    if (m_ovalid) check("out_payload", 64'(request_out.payload), 64'(m_opayload));
    check("count_model", 64'(packet_count_out), 64'(m_cnt));
    check("done_model", 64'(done_out), 64'(m_phase == PH_DONE));
    if (use_tab) begin
      check("count_table", 64'(packet_count_out), 64'(t_cnt));
      check("done_table", 64'(done_out), 64'(t_done));
    end
  endtask

  task automatic drive(input bit st, input bit rs, input bit rd, input logic [3:0] v,
                       input logic [3:0] dn, input int tag);
    start_in            = st;
    areset              = rs;
    downstream_ready_in = rd;
    requestor_done_in   = dn;
    for (int i = 0; i < N; i++) begin
      request_in[i].valid   = v[i];
      request_in[i].payload = {8'(i), 8'hC5, 16'(tag)};
    end
  endtask

  initial begin
    logic [3:0] rot;
    // reset, start, 8 round-robin grants
    add(1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 0, 1'b0);
    rot = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b0, 1'b1, 4'hF, 4'h0, rot, i + 1, 1'b0);
      rot = {rot[2:0], rot[3]};
    end
    // grant to 1 after ready drops (skew), three empty cycles, then 2
    add(1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 4'b0001,  9, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'b0010, 10, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'b0000, 10, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'b0000, 10, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 4'b0000, 10, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 4'b0100, 11, 1'b0);
    // single requester 2, back-to-back; count wraps at 16, 17th grant -> 1
    add(1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 4'b0100, 12, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 4'b0100, 13, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 4'b0100, 14, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 4'b0100, 15, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 4'b0100,  0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 4'b0100,  1, 1'b0);
    // all done with one packet still pending, then drain and done
    add(1'b0, 1'b0, 1'b1, 4'h1, 4'hF, 4'b0001,  2, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 4'b0000,  2, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 4'b0000,  2, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 4'b0000,  2, 1'b1);
    // restart clears count; start while active is ignored
    add(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 4'b0000,  0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 4'b0010,  1, 1'b0);
    // reset mid-stream, restart, requester 0 first
    add(1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 4'b0000,  0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 4'b0000,  0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 4'b0000,  0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 4'b0001,  1, 1'b0);

    m_phase = PH_IDLE; m_ptr = N - 1; m_rdy = 1'b0; m_ovalid = 1'b0; m_cnt = 0;
    m_opayload = 32'h0;

    foreach (tab[r]) begin
      drive(tab[r].start, tab[r].rst, tab[r].ready, tab[r].valid, tab[r].rdone, r);
      run_cycle(1'b1, tab[r].exp_grant, tab[r].exp_cnt, tab[r].exp_done);
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit         winding;
      logic [3:0] v;
      winding = ((c % 80) >= 50);
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, winding ? 5 : 1) == 0);
      start_in            = ($urandom_range(0, 15) == 0);
      areset              = ($urandom_range(0, 199) == 0);
      downstream_ready_in = ($urandom_range(0, 3) != 0);
      requestor_done_in   = winding ? 4'hF : 4'($urandom);
      for (int i = 0; i < N; i++) begin
        request_in[i].valid   = v[i];
        request_in[i].payload = $urandom;
      end
      run_cycle(1'b0, 4'h0, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
